// File: rtl/aes_sbox_pkg.sv
// AES S-box constants shared by the substitution datapath.
// Holds the FIPS-197 forward and inverse tables and a lookup helper.
// The inverse table is consumed only when SBOX_INV_EN is defined.
package aes_sbox_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Table lookup for software-side models and other blocks needing the same mapping.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/s_box_lut.sv
// Combinational 256-entry byte substitution table.
// INV=0 selects the forward AES S-box, INV=1 the inverse S-box.
// Written as a full case so it maps directly onto LUTs/ROM.
module s_box_lut #(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  // Full-coverage table decode; every code has an explicit entry.
  always_comb begin
    data_o = 8'h00;
    if (!INV) begin
      case (addr_i)
        8'h00: data_o = 8'h63; 8'h01: data_o = 8'h7c; 8'h02: data_o = 8'h77; 8'h03: data_o = 8'h7b; 8'h04: data_o = 8'hf2; 8'h05: data_o = 8'h6b; 8'h06: data_o = 8'h6f; 8'h07: data_o = 8'hc5;
        8'h08: data_o = 8'h30; 8'h09: data_o = 8'h01; 8'h0a: data_o = 8'h67; 8'h0b: data_o = 8'h2b; 8'h0c: data_o = 8'hfe; 8'h0d: data_o = 8'hd7; 8'h0e: data_o = 8'hab; 8'h0f: data_o = 8'h76;
        8'h10: data_o = 8'hca; 8'h11: data_o = 8'h82; 8'h12: data_o = 8'hc9; 8'h13: data_o = 8'h7d; 8'h14: data_o = 8'hfa; 8'h15: data_o = 8'h59; 8'h16: data_o = 8'h47; 8'h17: data_o = 8'hf0;
        8'h18: data_o = 8'had; 8'h19: data_o = 8'hd4; 8'h1a: data_o = 8'ha2; 8'h1b: data_o = 8'haf; 8'h1c: data_o = 8'h9c; 8'h1d: data_o = 8'ha4; 8'h1e: data_o = 8'h72; 8'h1f: data_o = 8'hc0;
        8'h20: data_o = 8'hb7; 8'h21: data_o = 8'hfd; 8'h22: data_o = 8'h93; 8'h23: data_o = 8'h26; 8'h24: data_o = 8'h36; 8'h25: data_o = 8'h3f; 8'h26: data_o = 8'hf7; 8'h27: data_o = 8'hcc;
        8'h28: data_o = 8'h34; 8'h29: data_o = 8'ha5; 8'h2a: data_o = 8'he5; 8'h2b: data_o = 8'hf1; 8'h2c: data_o = 8'h71; 8'h2d: data_o = 8'hd8; 8'h2e: data_o = 8'h31; 8'h2f: data_o = 8'h15;
        8'h30: data_o = 8'h04; 8'h31: data_o = 8'hc7; 8'h32: data_o = 8'h23; 8'h33: data_o = 8'hc3; 8'h34: data_o = 8'h18; 8'h35: data_o = 8'h96; 8'h36: data_o = 8'h05; 8'h37: data_o = 8'h9a;
        8'h38: data_o = 8'h07; 8'h39: data_o = 8'h12; 8'h3a: data_o = 8'h80; 8'h3b: data_o = 8'he2; 8'h3c: data_o = 8'heb; 8'h3d: data_o = 8'h27; 8'h3e: data_o = 8'hb2; 8'h3f: data_o = 8'h75;
        8'h40: data_o = 8'h09; 8'h41: data_o = 8'h83; 8'h42: data_o = 8'h2c; 8'h43: data_o = 8'h1a; 8'h44: data_o = 8'h1b; 8'h45: data_o = 8'h6e; 8'h46: data_o = 8'h5a; 8'h47: data_o = 8'ha0;
        8'h48: data_o = 8'h52; 8'h49: data_o = 8'h3b; 8'h4a: data_o = 8'hd6; 8'h4b: data_o = 8'hb3; 8'h4c: data_o = 8'h29; 8'h4d: data_o = 8'he3; 8'h4e: data_o = 8'h2f; 8'h4f: data_o = 8'h84;
        8'h50: data_o = 8'h53; 8'h51: data_o = 8'hd1; 8'h52: data_o = 8'h00; 8'h53: data_o = 8'hed; 8'h54: data_o = 8'h20; 8'h55: data_o = 8'hfc; 8'h56: data_o = 8'hb1; 8'h57: data_o = 8'h5b;
        8'h58: data_o = 8'h6a; 8'h59: data_o = 8'hcb; 8'h5a: data_o = 8'hbe; 8'h5b: data_o = 8'h39; 8'h5c: data_o = 8'h4a; 8'h5d: data_o = 8'h4c; 8'h5e: data_o = 8'h58; 8'h5f: data_o = 8'hcf;
        8'h60: data_o = 8'hd0; 8'h61: data_o = 8'hef; 8'h62: data_o = 8'haa; 8'h63: data_o = 8'hfb; 8'h64: data_o = 8'h43; 8'h65: data_o = 8'h4d; 8'h66: data_o = 8'h33; 8'h67: data_o = 8'h85;
        8'h68: data_o = 8'h45; 8'h69: data_o = 8'hf9; 8'h6a: data_o = 8'h02; 8'h6b: data_o = 8'h7f; 8'h6c: data_o = 8'h50; 8'h6d: data_o = 8'h3c; 8'h6e: data_o = 8'h9f; 8'h6f: data_o = 8'ha8;
        8'h70: data_o = 8'h51; 8'h71: data_o = 8'ha3; 8'h72: data_o = 8'h40; 8'h73: data_o = 8'h8f; 8'h74: data_o = 8'h92; 8'h75: data_o = 8'h9d; 8'h76: data_o = 8'h38; 8'h77: data_o = 8'hf5;
        8'h78: data_o = 8'hbc; 8'h79: data_o = 8'hb6; 8'h7a: data_o = 8'hda; 8'h7b: data_o = 8'h21; 8'h7c: data_o = 8'h10; 8'h7d: data_o = 8'hff; 8'h7e: data_o = 8'hf3; 8'h7f: data_o = 8'hd2;
        8'h80: data_o = 8'hcd; 8'h81: data_o = 8'h0c; 8'h82: data_o = 8'h13; 8'h83: data_o = 8'hec; 8'h84: data_o = 8'h5f; 8'h85: data_o = 8'h97; 8'h86: data_o = 8'h44; 8'h87: data_o = 8'h17;
        8'h88: data_o = 8'hc4; 8'h89: data_o = 8'ha7; 8'h8a: data_o = 8'h7e; 8'h8b: data_o = 8'h3d; 8'h8c: data_o = 8'h64; 8'h8d: data_o = 8'h5d; 8'h8e: data_o = 8'h19; 8'h8f: data_o = 8'h73;
        8'h90: data_o = 8'h60; 8'h91: data_o = 8'h81; 8'h92: data_o = 8'h4f; 8'h93: data_o = 8'hdc; 8'h94: data_o = 8'h22; 8'h95: data_o = 8'h2a; 8'h96: data_o = 8'h90; 8'h97: data_o = 8'h88;
        8'h98: data_o = 8'h46; 8'h99: data_o = 8'hee; 8'h9a: data_o = 8'hb8; 8'h9b: data_o = 8'h14; 8'h9c: data_o = 8'hde; 8'h9d: data_o = 8'h5e; 8'h9e: data_o = 8'h0b; 8'h9f: data_o = 8'hdb;
        8'ha0: data_o = 8'he0; 8'ha1: data_o = 8'h32; 8'ha2: data_o = 8'h3a; 8'ha3: data_o = 8'h0a; 8'ha4: data_o = 8'h49; 8'ha5: data_o = 8'h06; 8'ha6: data_o = 8'h24; 8'ha7: data_o = 8'h5c;
        8'ha8: data_o = 8'hc2; 8'ha9: data_o = 8'hd3; 8'haa: data_o = 8'hac; 8'hab: data_o = 8'h62; 8'hac: data_o = 8'h91; 8'had: data_o = 8'h95; 8'hae: data_o = 8'he4; 8'haf: data_o = 8'h79;
        8'hb0: data_o = 8'he7; 8'hb1: data_o = 8'hc8; 8'hb2: data_o = 8'h37; 8'hb3: data_o = 8'h6d; 8'hb4: data_o = 8'h8d; 8'hb5: data_o = 8'hd5; 8'hb6: data_o = 8'h4e; 8'hb7: data_o = 8'ha9;
        8'hb8: data_o = 8'h6c; 8'hb9: data_o = 8'h56; 8'hba: data_o = 8'hf4; 8'hbb: data_o = 8'hea; 8'hbc: data_o = 8'h65; 8'hbd: data_o = 8'h7a; 8'hbe: data_o = 8'hae; 8'hbf: data_o = 8'h08;
        8'hc0: data_o = 8'hba; 8'hc1: data_o = 8'h78; 8'hc2: data_o = 8'h25; 8'hc3: data_o = 8'h2e; 8'hc4: data_o = 8'h1c; 8'hc5: data_o = 8'ha6; 8'hc6: data_o = 8'hb4; 8'hc7: data_o = 8'hc6;
        8'hc8: data_o = 8'he8; 8'hc9: data_o = 8'hdd; 8'hca: data_o = 8'h74; 8'hcb: data_o = 8'h1f; 8'hcc: data_o = 8'h4b; 8'hcd: data_o = 8'hbd; 8'hce: data_o = 8'h8b; 8'hcf: data_o = 8'h8a;
        8'hd0: data_o = 8'h70; 8'hd1: data_o = 8'h3e; 8'hd2: data_o = 8'hb5; 8'hd3: data_o = 8'h66; 8'hd4: data_o = 8'h48; 8'hd5: data_o = 8'h03; 8'hd6: data_o = 8'hf6; 8'hd7: data_o = 8'h0e;
        8'hd8: data_o = 8'h61; 8'hd9: data_o = 8'h35; 8'hda: data_o = 8'h57; 8'hdb: data_o = 8'hb9; 8'hdc: data_o = 8'h86; 8'hdd: data_o = 8'hc1; 8'hde: data_o = 8'h1d; 8'hdf: data_o = 8'h9e;
        8'he0: data_o = 8'he1; 8'he1: data_o = 8'hf8; 8'he2: data_o = 8'h98; 8'he3: data_o = 8'h11; 8'he4: data_o = 8'h69; 8'he5: data_o = 8'hd9; 8'he6: data_o = 8'h8e; 8'he7: data_o = 8'h94;
        8'he8: data_o = 8'h9b; 8'he9: data_o = 8'h1e; 8'hea: data_o = 8'h87; 8'heb: data_o = 8'he9; 8'hec: data_o = 8'hce; 8'hed: data_o = 8'h55; 8'hee: data_o = 8'h28; 8'hef: data_o = 8'hdf;
        8'hf0: data_o = 8'h8c; 8'hf1: data_o = 8'ha1; 8'hf2: data_o = 8'h89; 8'hf3: data_o = 8'h0d; 8'hf4: data_o = 8'hbf; 8'hf5: data_o = 8'he6; 8'hf6: data_o = 8'h42; 8'hf7: data_o = 8'h68;
        8'hf8: data_o = 8'h41; 8'hf9: data_o = 8'h99; 8'hfa: data_o = 8'h2d; 8'hfb: data_o = 8'h0f; 8'hfc: data_o = 8'hb0; 8'hfd: data_o = 8'h54; 8'hfe: data_o = 8'hbb; 8'hff: data_o = 8'h16;
      endcase
    end else begin
      case (addr_i)
        8'h00: data_o = 8'h52; 8'h01: data_o = 8'h09; 8'h02: data_o = 8'h6a; 8'h03: data_o = 8'hd5; 8'h04: data_o = 8'h30; 8'h05: data_o = 8'h36; 8'h06: data_o = 8'ha5; 8'h07: data_o = 8'h38;
        8'h08: data_o = 8'hbf; 8'h09: data_o = 8'h40; 8'h0a: data_o = 8'ha3; 8'h0b: data_o = 8'h9e; 8'h0c: data_o = 8'h81; 8'h0d: data_o = 8'hf3; 8'h0e: data_o = 8'hd7; 8'h0f: data_o = 8'hfb;
        8'h10: data_o = 8'h7c; 8'h11: data_o = 8'he3; 8'h12: data_o = 8'h39; 8'h13: data_o = 8'h82; 8'h14: data_o = 8'h9b; 8'h15: data_o = 8'h2f; 8'h16: data_o = 8'hff; 8'h17: data_o = 8'h87;
        8'h18: data_o = 8'h34; 8'h19: data_o = 8'h8e; 8'h1a: data_o = 8'h43; 8'h1b: data_o = 8'h44; 8'h1c: data_o = 8'hc4; 8'h1d: data_o = 8'hde; 8'h1e: data_o = 8'he9; 8'h1f: data_o = 8'hcb;
        8'h20: data_o = 8'h54; 8'h21: data_o = 8'h7b; 8'h22: data_o = 8'h94; 8'h23: data_o = 8'h32; 8'h24: data_o = 8'ha6; 8'h25: data_o = 8'hc2; 8'h26: data_o = 8'h23; 8'h27: data_o = 8'h3d;
        8'h28: data_o = 8'hee; 8'h29: data_o = 8'h4c; 8'h2a: data_o = 8'h95; 8'h2b: data_o = 8'h0b; 8'h2c: data_o = 8'h42; 8'h2d: data_o = 8'hfa; 8'h2e: data_o = 8'hc3; 8'h2f: data_o = 8'h4e;
        8'h30: data_o = 8'h08; 8'h31: data_o = 8'h2e; 8'h32: data_o = 8'ha1; 8'h33: data_o = 8'h66; 8'h34: data_o = 8'h28; 8'h35: data_o = 8'hd9; 8'h36: data_o = 8'h24; 8'h37: data_o = 8'hb2;
        8'h38: data_o = 8'h76; 8'h39: data_o = 8'h5b; 8'h3a: data_o = 8'ha2; 8'h3b: data_o = 8'h49; 8'h3c: data_o = 8'h6d; 8'h3d: data_o = 8'h8b; 8'h3e: data_o = 8'hd1; 8'h3f: data_o = 8'h25;
        8'h40: data_o = 8'h72; 8'h41: data_o = 8'hf8; 8'h42: data_o = 8'hf6; 8'h43: data_o = 8'h64; 8'h44: data_o = 8'h86; 8'h45: data_o = 8'h68; 8'h46: data_o = 8'h98; 8'h47: data_o = 8'h16;
        8'h48: data_o = 8'hd4; 8'h49: data_o = 8'ha4; 8'h4a: data_o = 8'h5c; 8'h4b: data_o = 8'hcc; 8'h4c: data_o = 8'h5d; 8'h4d: data_o = 8'h65; 8'h4e: data_o = 8'hb6; 8'h4f: data_o = 8'h92;
        8'h50: data_o = 8'h6c; 8'h51: data_o = 8'h70; 8'h52: data_o = 8'h48; 8'h53: data_o = 8'h50; 8'h54: data_o = 8'hfd; 8'h55: data_o = 8'hed; 8'h56: data_o = 8'hb9; 8'h57: data_o = 8'hda;
        8'h58: data_o = 8'h5e; 8'h59: data_o = 8'h15; 8'h5a: data_o = 8'h46; 8'h5b: data_o = 8'h57; 8'h5c: data_o = 8'ha7; 8'h5d: data_o = 8'h8d; 8'h5e: data_o = 8'h9d; 8'h5f: data_o = 8'h84;
        8'h60: data_o = 8'h90; 8'h61: data_o = 8'hd8; 8'h62: data_o = 8'hab; 8'h63: data_o = 8'h00; 8'h64: data_o = 8'h8c; 8'h65: data_o = 8'hbc; 8'h66: data_o = 8'hd3; 8'h67: data_o = 8'h0a;
        8'h68: data_o = 8'hf7; 8'h69: data_o = 8'he4; 8'h6a: data_o = 8'h58; 8'h6b: data_o = 8'h05; 8'h6c: data_o = 8'hb8; 8'h6d: data_o = 8'hb3; 8'h6e: data_o = 8'h45; 8'h6f: data_o = 8'h06;
        8'h70: data_o = 8'hd0; 8'h71: data_o = 8'h2c; 8'h72: data_o = 8'h1e; 8'h73: data_o = 8'h8f; 8'h74: data_o = 8'hca; 8'h75: data_o = 8'h3f; 8'h76: data_o = 8'h0f; 8'h77: data_o = 8'h02;
        8'h78: data_o = 8'hc1; 8'h79: data_o = 8'haf; 8'h7a: data_o = 8'hbd; 8'h7b: data_o = 8'h03; 8'h7c: data_o = 8'h01; 8'h7d: data_o = 8'h13; 8'h7e: data_o = 8'h8a; 8'h7f: data_o = 8'h6b;
        8'h80: data_o = 8'h3a; 8'h81: data_o = 8'h91; 8'h82: data_o = 8'h11; 8'h83: data_o = 8'h41; 8'h84: data_o = 8'h4f; 8'h85: data_o = 8'h67; 8'h86: data_o = 8'hdc; 8'h87: data_o = 8'hea;
        8'h88: data_o = 8'h97; 8'h89: data_o = 8'hf2; 8'h8a: data_o = 8'hcf; 8'h8b: data_o = 8'hce; 8'h8c: data_o = 8'hf0; 8'h8d: data_o = 8'hb4; 8'h8e: data_o = 8'he6; 8'h8f: data_o = 8'h73;
        8'h90: data_o = 8'h96; 8'h91: data_o = 8'hac; 8'h92: data_o = 8'h74; 8'h93: data_o = 8'h22; 8'h94: data_o = 8'he7; 8'h95: data_o = 8'had; 8'h96: data_o = 8'h35; 8'h97: data_o = 8'h85;
        8'h98: data_o = 8'he2; 8'h99: data_o = 8'hf9; 8'h9a: data_o = 8'h37; 8'h9b: data_o = 8'he8; 8'h9c: data_o = 8'h1c; 8'h9d: data_o = 8'h75; 8'h9e: data_o = 8'hdf; 8'h9f: data_o = 8'h6e;
        8'ha0: data_o = 8'h47; 8'ha1: data_o = 8'hf1; 8'ha2: data_o = 8'h1a; 8'ha3: data_o = 8'h71; 8'ha4: data_o = 8'h1d; 8'ha5: data_o = 8'h29; 8'ha6: data_o = 8'hc5; 8'ha7: data_o = 8'h89;
        8'ha8: data_o = 8'h6f; 8'ha9: data_o = 8'hb7; 8'haa: data_o = 8'h62; 8'hab: data_o = 8'h0e; 8'hac: data_o = 8'haa; 8'had: data_o = 8'h18; 8'hae: data_o = 8'hbe; 8'haf: data_o = 8'h1b;
        8'hb0: data_o = 8'hfc; 8'hb1: data_o = 8'h56; 8'hb2: data_o = 8'h3e; 8'hb3: data_o = 8'h4b; 8'hb4: data_o = 8'hc6; 8'hb5: data_o = 8'hd2; 8'hb6: data_o = 8'h79; 8'hb7: data_o = 8'h20;
        8'hb8: data_o = 8'h9a; 8'hb9: data_o = 8'hdb; 8'hba: data_o = 8'hc0; 8'hbb: data_o = 8'hfe; 8'hbc: data_o = 8'h78; 8'hbd: data_o = 8'hcd; 8'hbe: data_o = 8'h5a; 8'hbf: data_o = 8'hf4;
        8'hc0: data_o = 8'h1f; 8'hc1: data_o = 8'hdd; 8'hc2: data_o = 8'ha8; 8'hc3: data_o = 8'h33; 8'hc4: data_o = 8'h88; 8'hc5: data_o = 8'h07; 8'hc6: data_o = 8'hc7; 8'hc7: data_o = 8'h31;
        8'hc8: data_o = 8'hb1; 8'hc9: data_o = 8'h12; 8'hca: data_o = 8'h10; 8'hcb: data_o = 8'h59; 8'hcc: data_o = 8'h27; 8'hcd: data_o = 8'h80; 8'hce: data_o = 8'hec; 8'hcf: data_o = 8'h5f;
        8'hd0: data_o = 8'h60; 8'hd1: data_o = 8'h51; 8'hd2: data_o = 8'h7f; 8'hd3: data_o = 8'ha9; 8'hd4: data_o = 8'h19; 8'hd5: data_o = 8'hb5; 8'hd6: data_o = 8'h4a; 8'hd7: data_o = 8'h0d;
        8'hd8: data_o = 8'h2d; 8'hd9: data_o = 8'he5; 8'hda: data_o = 8'h7a; 8'hdb: data_o = 8'h9f; 8'hdc: data_o = 8'h93; 8'hdd: data_o = 8'hc9; 8'hde: data_o = 8'h9c; 8'hdf: data_o = 8'hef;
        8'he0: data_o = 8'ha0; 8'he1: data_o = 8'he0; 8'he2: data_o = 8'h3b; 8'he3: data_o = 8'h4d; 8'he4: data_o = 8'hae; 8'he5: data_o = 8'h2a; 8'he6: data_o = 8'hf5; 8'he7: data_o = 8'hb0;
        8'he8: data_o = 8'hc8; 8'he9: data_o = 8'heb; 8'hea: data_o = 8'hbb; 8'heb: data_o = 8'h3c; 8'hec: data_o = 8'h83; 8'hed: data_o = 8'h53; 8'hee: data_o = 8'h99; 8'hef: data_o = 8'h61;
        8'hf0: data_o = 8'h17; 8'hf1: data_o = 8'h2b; 8'hf2: data_o = 8'h04; 8'hf3: data_o = 8'h7e; 8'hf4: data_o = 8'hba; 8'hf5: data_o = 8'h77; 8'hf6: data_o = 8'hd6; 8'hf7: data_o = 8'h26;
        8'hf8: data_o = 8'he1; 8'hf9: data_o = 8'h69; 8'hfa: data_o = 8'h14; 8'hfb: data_o = 8'h63; 8'hfc: data_o = 8'h55; 8'hfd: data_o = 8'h21; 8'hfe: data_o = 8'h0c; 8'hff: data_o = 8'h7d;
      endcase
    end
  end

endmodule

// File: rtl/s_box.sv
// AES byte substitution: zero-latency combinational result plus a
// 1-cycle registered copy with asynchronous active-high reset.
// Optional macro SBOX_INV_EN adds the Inv input, which selects the
// inverse S-box through a second table and a 2:1 mux.
module s_box
  import aes_sbox_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BYTE_W-1:0] Byte_In,
`ifdef SBOX_INV_EN
  input  logic              Inv,
`endif
  output logic [BYTE_W-1:0] Byte_Out,
  output logic [BYTE_W-1:0] Byte_Out_Reg
);

  logic [BYTE_W-1:0] fwd_byte;
  logic [BYTE_W-1:0] byte_out_reg_d;
  logic [BYTE_W-1:0] byte_out_reg_q;

  s_box_lut #(.INV(1'b0)) u_fwd_lut (
    .addr_i (Byte_In),
    .data_o (fwd_byte)
  );

`ifdef SBOX_INV_EN
  logic [BYTE_W-1:0] inv_byte;

  s_box_lut #(.INV(1'b1)) u_inv_lut (
    .addr_i (Byte_In),
    .data_o (inv_byte)
  );

  // Inv picks between forward and inverse tables; the register sees the muxed value.
  always_comb begin
    Byte_Out = Inv ? inv_byte : fwd_byte;
  end
`else
  // Forward table only.
  always_comb begin
    Byte_Out = fwd_byte;
  end
`endif

  // Next value of the output register is always the live substitution result.
  always_comb begin
    byte_out_reg_d = Byte_Out;
  end

  // Output register: cleared asynchronously, captures every rising edge otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      byte_out_reg_q <= '0;
    end else begin
      byte_out_reg_q <= byte_out_reg_d;
    end
  end

  assign Byte_Out_Reg = byte_out_reg_q;

endmodule

// File: tb/tb_s_box.sv
// Testbench for s_box. Reference values come from a GF(2^8) model
// (multiplicative inverse mod 0x11B followed by the affine map with 0x63).
// Define SBOX_INV_EN for both RTL and bench to exercise the inverse path.
module tb_s_box;

  logic       Clk;
  logic       Rst;
  logic [7:0] Byte_In;
  logic [7:0] Byte_Out;
  logic [7:0] Byte_Out_Reg;
`ifdef SBOX_INV_EN
  logic       Inv;
`endif

  int checks;
  int errors;

  logic [7:0] model_fwd [0:255];
  logic [7:0] model_inv [0:255];
  logic [7:0] exp_q [$];

  s_box dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Byte_In      (Byte_In),
`ifdef SBOX_INV_EN
    .Inv          (Inv),
`endif
    .Byte_Out     (Byte_Out),
    .Byte_Out_Reg (Byte_Out_Reg)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(a, 8'(c)) == 8'h01) r = 8'(c);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) model_fwd[x] = sbox_model(8'(x));
    for (int x = 0; x < 256; x++) model_inv[model_fwd[x]] = 8'(x);
  endtask

  // ---------------- driver tasks / scenarios ----------------
  task automatic test_reset();
    Rst = 1'b1;
    Byte_In = 8'h00;
`ifdef SBOX_INV_EN
    Inv = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h00) begin
      errors++;
      $display("FAIL reset_reg: got %h expected 00", Byte_Out_Reg);
    end
    checks++;
    if (Byte_Out !== 8'h63) begin
      errors++;
      $display("FAIL reset_comb: got %h expected 63", Byte_Out);
    end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] spot_in  [0:4];
    logic [7:0] spot_out [0:4];
    spot_in  = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hff};
    spot_out = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'h16};
    for (int x = 0; x < 256; x++) begin
      Byte_In = 8'(x);
      #10;
      checks++;
      if (Byte_Out !== model_fwd[x]) begin
        errors++;
        $display("FAIL sweep[%02h]: got %h expected %h", x[7:0], Byte_Out, model_fwd[x]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      Byte_In = spot_in[i];
      #10;
      checks++;
      if (Byte_Out !== spot_out[i]) begin
        errors++;
        $display("FAIL spot[%02h]: got %h expected %h", spot_in[i], Byte_Out, spot_out[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge Clk);
    Byte_In = 8'h01;
    @(posedge Clk);
    @(negedge Clk);
    Byte_In = 8'h53;
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h7c) begin
      errors++;
      $display("FAIL reg_hold: got %h expected 7c", Byte_Out_Reg);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'hed) begin
      errors++;
      $display("FAIL reg_load: got %h expected ed", Byte_Out_Reg);
    end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_reg: got %h expected 00", Byte_Out_Reg);
    end
    checks++;
    if (Byte_Out !== 8'hed) begin
      errors++;
      $display("FAIL async_reset_comb: got %h expected ed", Byte_Out);
    end
  endtask

  task automatic test_reset_release();
    Byte_In = 8'hff;
    @(negedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h00) begin
      errors++;
      $display("FAIL release_hold: got %h expected 00", Byte_Out_Reg);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h16) begin
      errors++;
      $display("FAIL release_load: got %h expected 16", Byte_Out_Reg);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [0:3];
    logic [7:0] want [0:3];
    logic [7:0] exp;
    seq  = '{8'h00, 8'hff, 8'h01, 8'h10};
    want = '{8'h63, 8'h16, 8'h7c, 8'hca};
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Byte_In = seq[i];
      exp_q.push_back(model_fwd[seq[i]]);
      @(posedge Clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (Byte_Out_Reg !== exp || Byte_Out_Reg !== want[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, Byte_Out_Reg, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] exp;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      v = 8'($urandom_range(0, 255));
      Byte_In = v;
      exp_q.push_back(model_fwd[v]);
      #1;
      checks++;
      if (Byte_Out !== model_fwd[v]) begin
        errors++;
        $display("FAIL rand_comb[%02h]: got %h expected %h", v, Byte_Out, model_fwd[v]);
      end
      @(posedge Clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (Byte_Out_Reg !== exp) begin
        errors++;
        $display("FAIL rand_reg[%02h]: got %h expected %h", v, Byte_Out_Reg, exp);
      end
    end
  endtask

`ifdef SBOX_INV_EN
  task automatic test_inverse();
    logic [7:0] spot_in  [0:3];
    logic [7:0] spot_out [0:3];
    spot_in  = '{8'h63, 8'hed, 8'h16, 8'h7c};
    spot_out = '{8'h00, 8'h53, 8'hff, 8'h01};
    Inv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Byte_In = spot_in[i];
      #10;
      checks++;
      if (Byte_Out !== spot_out[i]) begin
        errors++;
        $display("FAIL inv_spot[%02h]: got %h expected %h", spot_in[i], Byte_Out, spot_out[i]);
      end
    end
    for (int x = 0; x < 256; x++) begin
      Byte_In = model_fwd[x];
      #10;
      checks++;
      if (Byte_Out !== 8'(x) || Byte_Out !== model_inv[model_fwd[x]]) begin
        errors++;
        $display("FAIL inv_roundtrip[%02h]: got %h expected %h", x[7:0], Byte_Out, x[7:0]);
      end
    end
    @(negedge Clk);
    Byte_In = 8'hed;
    @(posedge Clk);
    #1;
    checks++;
    if (Byte_Out_Reg !== 8'h53) begin
      errors++;
      $display("FAIL inv_reg: got %h expected 53", Byte_Out_Reg);
    end
    @(negedge Clk);
    Inv = 1'b0;
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    checks = 0;
    errors = 0;
    build_model();
    test_reset();
    test_sweep();
    test_registered();
    test_async_reset();
    test_reset_release();
    test_back_to_back();
    test_random();
`ifdef SBOX_INV_EN
    test_inverse();
`endif
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
